// File: rtl/multicycle_control_if.sv
// Memory port between the multicycle control unit and the shared instruction/data memory.
// The master is the controller; the slave is the memory.
interface multicycle_control_if;
   logic mem_read_o;
   logic mem_write_o;
   logic i_or_d_o;
   logic mem_ack_i;

   modport master (
      output mem_read_o,
      output mem_write_o,
      output i_or_d_o,
      input  mem_ack_i
   );

   modport slave (
      input  mem_read_o,
      input  mem_write_o,
      input  i_or_d_o,
      output mem_ack_i
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing with ack timeout and traps.
// Optional macro MULTICYCLE_BRANCH_EN adds the BRANCH state for BEQ/BNE.
module multicycle_control #(
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [5:0]           opcode_i,
   input  logic                 zero_i,
   multicycle_control_if.master mem_if,
   output logic                 pc_write_o,
   output logic                 ir_write_o,
   output logic                 reg_dst_o,
   output logic                 mem_to_reg_o,
   output logic                 reg_write_o,
   output logic                 alu_src_a_o,
   output logic [1:0]           alu_src_b_o,
   output logic [1:0]           pc_source_o,
   output logic [ALU_OP_W-1:0]  alu_op_o,
   output logic [3:0]           state_o,
   output logic                 illegal_op_o,
   output logic                 bus_err_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      WB_R     = 4'd3,
      EXEC_I   = 4'd4,
      WB_I     = 4'd5,
      MEM_ADDR = 4'd6,
      MEM_RD   = 4'd7,
      WB_MEM   = 4'd8,
      MEM_WR   = 4'd9,
`ifdef MULTICYCLE_BRANCH_EN
      BRANCH   = 4'd10,
`endif
      TRAP     = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
`ifdef MULTICYCLE_BRANCH_EN
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
`endif

   localparam logic [ALU_OP_W-1:0] ALU_LUI   = ALU_OP_W'(3'd0);
   localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(3'd1);
   localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(3'd2);
   localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(3'd4);
   localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(3'd6);
   localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(3'd7);

   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   state_e      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [5:0]  opcode_q, opcode_d;
   logic        illegal_op_q, illegal_op_d;
   logic        bus_err_q, bus_err_d;
   logic        trap_bus_q, trap_bus_d;

   logic [7:0]  wait_inc;
   logic        timeout_hit;
   logic        mem_read, mem_write, i_or_d;

   assign wait_inc    = wait_cnt_q + 8'd1;
   assign timeout_hit = (wait_inc == TIMEOUT_CNT);

`ifndef MULTICYCLE_BRANCH_EN
   logic unused_zero;
   assign unused_zero = zero_i;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= FETCH;
         wait_cnt_q   <= 8'd0;
         opcode_q     <= 6'd0;
         illegal_op_q <= 1'b0;
         bus_err_q    <= 1'b0;
         trap_bus_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         opcode_q     <= opcode_d;
         illegal_op_q <= illegal_op_d;
         bus_err_q    <= bus_err_d;
         trap_bus_q   <= trap_bus_d;
      end
   end

   // The wait counter only survives while a memory state holds; any transition clears it,
   // and an ack in the cycle the limit would be reached still takes the normal path.
   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = 8'd0;
      opcode_d     = opcode_q;
      illegal_op_d = illegal_op_q;
      bus_err_d    = bus_err_q;
      trap_bus_d   = trap_bus_q;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      i_or_d       = 1'b0;
      pc_write_o   = 1'b0;
      ir_write_o   = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'd0;
      pc_source_o  = 2'd0;
      alu_op_o     = ALU_LUI;

      case (state_q)
         FETCH: begin
            mem_read    = 1'b1;
            alu_src_b_o = 2'd1;
            alu_op_o    = ALU_ADD;
            if (mem_if.mem_ack_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_d    = DECODE;
            end else if (timeout_hit) begin
               bus_err_d  = 1'b1;
               trap_bus_d = 1'b1;
               state_d    = TRAP;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end

         DECODE: begin
            alu_src_b_o = 2'd3;
            alu_op_o    = ALU_ADD;
            opcode_d    = opcode_i;
            case (opcode_i)
               OP_RTYPE:                         state_d = EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = EXEC_I;
               OP_LW, OP_SW:                     state_d = MEM_ADDR;
`ifdef MULTICYCLE_BRANCH_EN
               OP_BEQ, OP_BNE:                   state_d = BRANCH;
`endif
               default: begin
                  trap_bus_d = 1'b0;
                  state_d    = TRAP;
               end
            endcase
         end

         EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd0;
            alu_op_o    = ALU_FUNCT;
            state_d     = WB_R;
         end

         WB_R: begin
            reg_dst_o   = 1'b1;
            reg_write_o = 1'b1;
            state_d     = FETCH;
         end

         EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd2;
            case (opcode_q)
               OP_ANDI: alu_op_o = ALU_AND;
               OP_ORI:  alu_op_o = ALU_OR;
               OP_LUI:  alu_op_o = ALU_LUI;
               default: alu_op_o = ALU_ADD;
            endcase
            state_d = WB_I;
         end

         WB_I: begin
            reg_write_o = 1'b1;
            state_d     = FETCH;
         end

         MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd2;
            alu_op_o    = ALU_ADD;
            state_d     = (opcode_q == OP_SW) ? MEM_WR : MEM_RD;
         end

         MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_if.mem_ack_i) begin
               state_d = WB_MEM;
            end else if (timeout_hit) begin
               bus_err_d  = 1'b1;
               trap_bus_d = 1'b1;
               state_d    = TRAP;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end

         WB_MEM: begin
            mem_to_reg_o = 1'b1;
            reg_write_o  = 1'b1;
            state_d      = FETCH;
         end

         MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_if.mem_ack_i) begin
               state_d = FETCH;
            end else if (timeout_hit) begin
               bus_err_d  = 1'b1;
               trap_bus_d = 1'b1;
               state_d    = TRAP;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end

`ifdef MULTICYCLE_BRANCH_EN
         BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'd0;
            alu_op_o    = ALU_SUB;
            pc_source_o = 2'd1;
            pc_write_o  = (opcode_q == OP_BNE) ? !zero_i : zero_i;
            state_d     = FETCH;
         end
`endif

         // Bus errors were already flagged on the way in; only decode traps raise illegal_op here.
         TRAP: begin
            if (!trap_bus_q) begin
               illegal_op_d = 1'b1;
            end
            state_d = FETCH;
         end

         default: state_d = FETCH;
      endcase
   end

   assign mem_if.mem_read_o  = mem_read;
   assign mem_if.mem_write_o = mem_write;
   assign mem_if.i_or_d_o    = i_or_d;
   assign state_o            = state_q;
   assign illegal_op_o       = illegal_op_q;
   assign bus_err_o          = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4); BRANCH checks follow MULTICYCLE_BRANCH_EN.
module tb_multicycle_control;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic [5:0] opcode_i;
   logic       zero_i;
   logic       pc_write_o, ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
   logic [1:0] alu_src_b_o, pc_source_o;
   logic [2:0] alu_op_o;
   logic [3:0] state_o;
   logic       illegal_op_o, bus_err_o;

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_control_if mem_if ();

   always #5 clk_i = ~clk_i;

   multicycle_control #(
      .ALU_OP_W    (3),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .opcode_i     (opcode_i),
      .zero_i       (zero_i),
      .mem_if       (mem_if.master),
      .pc_write_o   (pc_write_o),
      .ir_write_o   (ir_write_o),
      .reg_dst_o    (reg_dst_o),
      .mem_to_reg_o (mem_to_reg_o),
      .reg_write_o  (reg_write_o),
      .alu_src_a_o  (alu_src_a_o),
      .alu_src_b_o  (alu_src_b_o),
      .pc_source_o  (pc_source_o),
      .alu_op_o     (alu_op_o),
      .state_o      (state_o),
      .illegal_op_o (illegal_op_o),
      .bus_err_o    (bus_err_o)
   );

   task automatic do_reset();
      rst_n_i = 1'b0;
      mem_if.mem_ack_i = 1'b0;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset();
      logic [11:0] others;
      rst_n_i = 1'b0;
      mem_if.mem_ack_i = 1'b0;
      opcode_i = 6'h3f;
      zero_i = 1'b0;
      @(posedge clk_i); #1;
      others = {pc_write_o, ir_write_o, mem_if.i_or_d_o, mem_if.mem_write_o, reg_dst_o, mem_to_reg_o,
                reg_write_o, alu_src_a_o, pc_source_o, illegal_op_o, bus_err_o};
      n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
      n_checks++; if (mem_if.mem_read_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_mem_read: got %b expected 1", mem_if.mem_read_o); end
      n_checks++; if (alu_src_b_o !== 2'd1) begin n_fail++; $display("[TB] FAIL reset_src_b: got %0d expected 1", alu_src_b_o); end
      n_checks++; if (alu_op_o !== 3'd4) begin n_fail++; $display("[TB] FAIL reset_alu_op: got %0d expected 4", alu_op_o); end
      n_checks++; if (others !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_others: got %h expected 000", others); end
      rst_n_i = 1'b1;
   endtask

   task automatic test_addi();
      int exp_st [5] = '{0, 1, 4, 5, 0};
      do_reset();
      mem_if.mem_ack_i = 1'b1;
      opcode_i = 6'h08;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++; if (state_o !== 4'(exp_st[c])) begin n_fail++; $display("[TB] FAIL addi_state c%0d: got %0d expected %0d", c, state_o, exp_st[c]); end
         n_checks++; if (reg_write_o !== (exp_st[c] == 5)) begin n_fail++; $display("[TB] FAIL addi_reg_write c%0d: got %b expected %b", c, reg_write_o, exp_st[c] == 5); end
         if (exp_st[c] == 4) begin
            n_checks++; if (alu_op_o !== 3'd4) begin n_fail++; $display("[TB] FAIL addi_alu_op: got %0d expected 4", alu_op_o); end
         end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_itype_ops();
      logic [5:0] ops  [3] = '{6'h0c, 6'h0d, 6'h0f};
      logic [2:0] alus [3] = '{3'd2, 3'd1, 3'd0};
      for (int k = 0; k < 3; k++) begin
         do_reset();
         mem_if.mem_ack_i = 1'b1;
         opcode_i = ops[k];
         @(posedge clk_i); #1;
         @(posedge clk_i); #1;
         n_checks++; if (state_o !== 4'd4) begin n_fail++; $display("[TB] FAIL itype_state op%h: got %0d expected 4", ops[k], state_o); end
         n_checks++; if (alu_op_o !== alus[k]) begin n_fail++; $display("[TB] FAIL itype_alu op%h: got %0d expected %0d", ops[k], alu_op_o, alus[k]); end
      end
   endtask

   task automatic test_lw_wait();
      int   exp_st [9] = '{0, 1, 6, 7, 7, 7, 7, 8, 0};
      logic acks   [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
      do_reset();
      opcode_i = 6'h23;
      for (int c = 0; c < 9; c++) begin
         mem_if.mem_ack_i = acks[c];
         #1;
         n_checks++; if (state_o !== 4'(exp_st[c])) begin n_fail++; $display("[TB] FAIL lw_state c%0d: got %0d expected %0d", c, state_o, exp_st[c]); end
         if (exp_st[c] == 7) begin
            n_checks++; if (mem_if.i_or_d_o !== 1'b1) begin n_fail++; $display("[TB] FAIL lw_i_or_d c%0d: got %b expected 1", c, mem_if.i_or_d_o); end
         end
         if (exp_st[c] == 8) begin
            n_checks++; if ({mem_to_reg_o, reg_write_o} !== 2'b11) begin n_fail++; $display("[TB] FAIL lw_wb: got %b expected 11", {mem_to_reg_o, reg_write_o}); end
         end
         n_checks++; if (bus_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_bus_err c%0d: got %b expected 0", c, bus_err_o); end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_sw_timeout();
      int   exp_st [9] = '{0, 1, 6, 9, 9, 9, 9, 11, 0};
      logic acks   [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 1};
      int   ok_st  [8] = '{0, 1, 6, 9, 9, 9, 9, 0};
      logic ok_ack [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
      do_reset();
      opcode_i = 6'h2b;
      for (int c = 0; c < 9; c++) begin
         mem_if.mem_ack_i = acks[c];
         #1;
         n_checks++; if (state_o !== 4'(exp_st[c])) begin n_fail++; $display("[TB] FAIL sw_to_state c%0d: got %0d expected %0d", c, state_o, exp_st[c]); end
         n_checks++; if (mem_if.mem_write_o !== (exp_st[c] == 9)) begin n_fail++; $display("[TB] FAIL sw_to_mem_write c%0d: got %b expected %b", c, mem_if.mem_write_o, exp_st[c] == 9); end
         n_checks++; if (bus_err_o !== (c >= 7)) begin n_fail++; $display("[TB] FAIL sw_to_bus_err c%0d: got %b expected %b", c, bus_err_o, c >= 7); end
         if (c == 8) begin
            n_checks++; if (illegal_op_o !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_to_illegal: got %b expected 0", illegal_op_o); end
         end
         @(posedge clk_i); #1;
      end
      do_reset();
      for (int c = 0; c < 8; c++) begin
         mem_if.mem_ack_i = ok_ack[c];
         #1;
         n_checks++; if (state_o !== 4'(ok_st[c])) begin n_fail++; $display("[TB] FAIL sw_late_ack_state c%0d: got %0d expected %0d", c, state_o, ok_st[c]); end
         n_checks++; if (bus_err_o !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_late_ack_bus_err c%0d: got %b expected 0", c, bus_err_o); end
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_branch();
`ifdef MULTICYCLE_BRANCH_EN
      logic [5:0] ops   [3] = '{6'h04, 6'h04, 6'h05};
      logic       zeros [3] = '{1'b1, 1'b0, 1'b0};
      logic       pcw   [3] = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         do_reset();
         mem_if.mem_ack_i = 1'b1;
         opcode_i = ops[k];
         zero_i = zeros[k];
         @(posedge clk_i); #1;
         @(posedge clk_i); #1;
         n_checks++; if (state_o !== 4'd10) begin n_fail++; $display("[TB] FAIL branch_state k%0d: got %0d expected 10", k, state_o); end
         n_checks++; if (pc_write_o !== pcw[k]) begin n_fail++; $display("[TB] FAIL branch_pc_write k%0d: got %b expected %b", k, pc_write_o, pcw[k]); end
         n_checks++; if (pc_source_o !== 2'd1) begin n_fail++; $display("[TB] FAIL branch_pc_source k%0d: got %0d expected 1", k, pc_source_o); end
         n_checks++; if (alu_op_o !== 3'd6) begin n_fail++; $display("[TB] FAIL branch_alu_op k%0d: got %0d expected 6", k, alu_op_o); end
         @(posedge clk_i); #1;
         n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("[TB] FAIL branch_return k%0d: got %0d expected 0", k, state_o); end
      end
`else
      do_reset();
      mem_if.mem_ack_i = 1'b1;
      opcode_i = 6'h04;
      zero_i = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      n_checks++; if (state_o !== 4'd11) begin n_fail++; $display("[TB] FAIL beq_off_state: got %0d expected 11", state_o); end
      n_checks++; if ({pc_write_o, pc_source_o} !== 3'b000) begin n_fail++; $display("[TB] FAIL beq_off_pc: got %b expected 000", {pc_write_o, pc_source_o}); end
      @(posedge clk_i); #1;
      n_checks++; if (illegal_op_o !== 1'b1) begin n_fail++; $display("[TB] FAIL beq_off_illegal: got %b expected 1", illegal_op_o); end
`endif
   endtask

   // Illegal opcode, then ADDI and an R-type with the flag still set, reset during WB_R.
   task automatic test_illegal_sticky_reset();
      int         exp_st [11] = '{0, 1, 11, 0, 1, 4, 5, 0, 1, 2, 3};
      logic [5:0] ops    [11] = '{6'h3f, 6'h3f, 6'h3f, 6'h08, 6'h08, 6'h08, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00};
      do_reset();
      mem_if.mem_ack_i = 1'b1;
      for (int c = 0; c < 11; c++) begin
         opcode_i = ops[c];
         #1;
         n_checks++; if (state_o !== 4'(exp_st[c])) begin n_fail++; $display("[TB] FAIL sticky_state c%0d: got %0d expected %0d", c, state_o, exp_st[c]); end
         n_checks++; if (illegal_op_o !== (c >= 3)) begin n_fail++; $display("[TB] FAIL sticky_illegal c%0d: got %b expected %b", c, illegal_op_o, c >= 3); end
         if (c == 9) begin
            n_checks++; if ({alu_op_o, alu_src_a_o, alu_src_b_o} !== 6'b111_1_00) begin n_fail++; $display("[TB] FAIL exec_r_ctrl: got %b expected 111100", {alu_op_o, alu_src_a_o, alu_src_b_o}); end
         end
         if (c == 10) begin
            n_checks++; if ({reg_dst_o, reg_write_o} !== 2'b11) begin n_fail++; $display("[TB] FAIL wb_r_ctrl: got %b expected 11", {reg_dst_o, reg_write_o}); end
            rst_n_i = 1'b0;
         end
         @(posedge clk_i); #1;
      end
      n_checks++; if (state_o !== 4'd0) begin n_fail++; $display("[TB] FAIL midreset_state: got %0d expected 0", state_o); end
      n_checks++; if (reg_write_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_reg_write: got %b expected 0", reg_write_o); end
      n_checks++; if ({illegal_op_o, bus_err_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL midreset_flags: got %b expected 00", {illegal_op_o, bus_err_o}); end
      rst_n_i = 1'b1;
   endtask

   initial begin
      $display("[TB] starting multicycle_control bench");
      test_reset();
      test_addi();
      test_itype_ops();
      test_lw_wait();
      test_sw_timeout();
      test_branch();
      test_illegal_sticky_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
